// File: rtl/instr_encoder_if.sv
// Field-tuple handshake and instruction-memory write bus for instr_encoder.
// master = tuple source / memory side, slave = the encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        fmt;
   logic [3:0]        op;
   logic [3:0]        rd;
   logic [3:0]        rs;
   logic [3:0]        rt;
   logic [11:0]       imm;
   logic              last;
   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   word_count;
   logic              err;

   modport master (
      output start, base_addr, in_valid, fmt, op, rd, rs, rt, imm, last, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, word_count, err
   );

   modport slave (
      input  start, base_addr, in_valid, fmt, op, rd, rs, rt, imm, last, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, word_count, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction field tuples into 16-bit words and writes them to program memory.
// ENC_WRAP_EN: when defined, the write address wraps past the top instead of saturating.
module instr_encoder #(
   parameter int unsigned ADDR_W = 8
) (
   input logic             clk,
   input logic             rst,
   instr_encoder_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

   state_e            state_q;
   logic [15:0]       buf_q [2];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   wcnt_q;
   logic              err_q;
   logic              done_q;
   logic              sat_q;

   logic [15:0] enc_word;
   logic        hs;
   logic        push;
   logic        pop;
   logic        wr_done;
   logic [1:0]  cnt_d;

   always_comb begin
      enc_word = 16'h0000;
      unique case (bus.fmt)
         2'd0:    enc_word = {bus.op, bus.rd, bus.rs, bus.rt};
         2'd1:    enc_word = {bus.op, bus.rd, bus.imm[7:0]};
         2'd2:    enc_word = {bus.op, bus.imm};
         default: enc_word = 16'h0000;
      endcase
   end

   assign bus.in_ready   = (state_q == StLoad) && (cnt_q < 2'd2);
   assign bus.mem_we     = (cnt_q != 2'd0) && !sat_q;
   assign bus.mem_wdata  = buf_q[rd_ptr_q];
   assign bus.mem_addr   = addr_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.done       = done_q;
   assign bus.word_count = wcnt_q;
   assign bus.err        = err_q;

   assign hs      = bus.in_valid && bus.in_ready;
   assign push    = hs && (bus.fmt != 2'd3);
   assign wr_done = bus.mem_we && bus.mem_ready;
   // Once saturated, entries drain one per cycle without touching memory.
   assign pop     = (cnt_q != 2'd0) && (sat_q || bus.mem_ready);
   assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         buf_q[0] <= 16'h0000;
         buf_q[1] <= 16'h0000;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         addr_q   <= '0;
         wcnt_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         cnt_q  <= cnt_d;
         if (push) begin
            buf_q[wr_ptr_q] <= enc_word;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         if (hs && (bus.fmt == 2'd3)) err_q <= 1'b1;
         if (wr_done) begin
            wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
`ifdef ENC_WRAP_EN
            addr_q <= addr_q + ADDR_W'(1);
`else
            if (addr_q == '1) begin
               sat_q <= 1'b1;
               err_q <= 1'b1;
            end else begin
               addr_q <= addr_q + ADDR_W'(1);
            end
`endif
         end

         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StLoad;
                  addr_q  <= bus.base_addr;
                  wcnt_q  <= '0;
                  err_q   <= 1'b0;
                  sat_q   <= 1'b0;
               end
            end
            StLoad: begin
               if (hs && bus.last) state_q <= StDrain;
            end
            StDrain: begin
               // Leave on the cycle the final pop happens so done and busy move together.
               if (cnt_d == 2'd0) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, backpressure, reserved fmt,
// address end, mid-session reset and start-during-load.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      logic [1:0]  fmt;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic [11:0] imm;
      logic        wr;
      logic [15:0] word;
   } vec_t;
   vec_t vecs[7];

   instr_encoder_if #(.ADDR_W(8)) bus ();

   instr_encoder #(.ADDR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.mem_we && bus.mem_ready) wq.push_back('{bus.mem_addr, bus.mem_wdata, cyc});
      if (bus.done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_wr(input string name, input int idx, input logic [7:0] a,
                         input logic [15:0] d);
      if (idx < wq.size()) begin
         chk({name, "_addr"}, 32'(wq[idx].addr), 32'(a));
         chk({name, "_data"}, 32'(wq[idx].data), 32'(d));
      end else begin
         chk({name, "_missing"}, 32'(wq.size()), 32'(idx + 1));
      end
   endtask

   task automatic start_session(input logic [7:0] base);
      wq.delete();
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = base;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic send(input logic [1:0] f, input logic [3:0] o, input logic [3:0] d,
                       input logic [3:0] s, input logic [3:0] t, input logic [11:0] im,
                       input logic lst);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.fmt = f; bus.op = o; bus.rd = d; bus.rs = s; bus.rt = t; bus.imm = im;
      bus.last = lst;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.last = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < 100) begin
         @(negedge clk);
         #1 n++;
      end
      chk({name, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
      chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{2'd0, 4'hA, 4'h1, 4'h2, 4'h3, 12'hFFF, 1'b1, 16'hA123};
      vecs[1] = '{2'd1, 4'h3, 4'hC, 4'hF, 4'hF, 12'h5A7, 1'b1, 16'h3CA7};
      vecs[2] = '{2'd3, 4'h7, 4'h7, 4'h7, 4'h7, 12'h777, 1'b0, 16'h0000};
      vecs[3] = '{2'd2, 4'h0, 4'hF, 4'hF, 4'hF, 12'hABC, 1'b1, 16'h0ABC};
      vecs[4] = '{2'd0, 4'hF, 4'hF, 4'hF, 4'hF, 12'h000, 1'b1, 16'hFFFF};
      vecs[5] = '{2'd1, 4'h0, 4'h0, 4'h5, 4'h5, 12'hF00, 1'b1, 16'h0000};
      vecs[6] = '{2'd2, 4'h9, 4'h1, 4'h2, 4'h3, 12'h001, 1'b1, 16'h9001};

      rst = 1'b1;
      bus.start = 1'b0; bus.base_addr = 8'h00; bus.in_valid = 1'b0; bus.fmt = 2'd0;
      bus.op = 4'h0; bus.rd = 4'h0; bus.rs = 4'h0; bus.rt = 4'h0; bus.imm = 12'h000;
      bus.last = 1'b0; bus.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_word_count", 32'(bus.word_count), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst = 1'b0;

      // Basic session, memory always ready.
      start_session(8'h10);
      chk("basic_busy", 32'(bus.busy), 32'd1);
      send(2'd0, 4'h1, 4'h2, 4'h3, 4'h4, 12'h000, 1'b0);
      send(2'd1, 4'h5, 4'h6, 4'h0, 4'h0, 12'h0AB, 1'b0);
      send(2'd2, 4'hF, 4'h0, 4'h0, 4'h0, 12'h123, 1'b1);
      wait_done("basic");
      chk("basic_nwrites", 32'(wq.size()), 32'd3);
      chk_wr("basic_w0", 0, 8'h10, 16'h1234);
      chk_wr("basic_w1", 1, 8'h11, 16'h56AB);
      chk_wr("basic_w2", 2, 8'h12, 16'hF123);
      if (wq.size() == 3) begin
         chk("basic_back_to_back", 32'(wq[2].cyc - wq[0].cyc), 32'd2);
         chk("basic_done_latency", 32'(done_cyc - wq[2].cyc), 32'd1);
      end
      repeat (2) @(negedge clk);
      chk("basic_word_count", 32'(bus.word_count), 32'd3);
      chk("basic_err", 32'(bus.err), 32'd0);
      chk("basic_idle_ready", 32'(bus.in_ready), 32'd0);

      // Encoding table, including a reserved fmt in the middle.
      begin
         int j = 0;
         int nw = 0;
         start_session(8'h40);
         for (int i = 0; i < 7; i++)
            send(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm,
                 (i == 6) ? 1'b1 : 1'b0);
         wait_done("tbl");
         for (int i = 0; i < 7; i++) if (vecs[i].wr) nw++;
         chk("tbl_nwrites", 32'(wq.size()), 32'(nw));
         for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) begin
               chk_wr($sformatf("tbl_v%0d", i), j, 8'h40 + 8'(j), vecs[i].word);
               j++;
            end
         end
         chk("tbl_word_count", 32'(bus.word_count), 32'(nw));
         chk("tbl_err", 32'(bus.err), 32'd1);
      end

      // Backpressure: two tuples fill the buffer, then in_ready drops.
      start_session(8'h60);
      chk("bp_err_cleared", 32'(bus.err), 32'd0);
      bus.mem_ready = 1'b0;
      send(2'd0, 4'h2, 4'h1, 4'h1, 4'h1, 12'h000, 1'b0);
      send(2'd1, 4'h4, 4'h2, 4'h0, 4'h0, 12'h033, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_ready_low%0d", k), 32'(bus.in_ready), 32'd0);
         chk($sformatf("bp_we_high%0d", k), 32'(bus.mem_we), 32'd1);
      end
      chk("bp_no_writes", 32'(wq.size()), 32'd0);
      chk("bp_head", 32'(bus.mem_wdata), 32'h2111);
      @(posedge clk);
      #1 bus.mem_ready = 1'b1;
      send(2'd2, 4'h8, 4'h0, 4'h0, 4'h0, 12'h456, 1'b1);
      wait_done("bp");
      chk("bp_nwrites", 32'(wq.size()), 32'd3);
      chk_wr("bp_w0", 0, 8'h60, 16'h2111);
      chk_wr("bp_w1", 1, 8'h61, 16'h4233);
      chk_wr("bp_w2", 2, 8'h62, 16'h8456);
      chk("bp_word_count", 32'(bus.word_count), 32'd3);

      // start during LOAD is ignored.
      start_session(8'h20);
      send(2'd0, 4'h1, 4'h1, 4'h1, 4'h1, 12'h000, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 8'h80;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("sl_addr", 32'(bus.mem_addr), 32'h21);
      chk("sl_word_count", 32'(bus.word_count), 32'd1);
      send(2'd1, 4'h2, 4'h2, 4'h0, 4'h0, 12'h022, 1'b0);
      send(2'd2, 4'h3, 4'h0, 4'h0, 4'h0, 12'h333, 1'b1);
      wait_done("sl");
      chk("sl_nwrites", 32'(wq.size()), 32'd3);
      chk_wr("sl_w2", 2, 8'h22, 16'h3333);
      chk("sl_word_count_end", 32'(bus.word_count), 32'd3);

      // Reset mid-session after one word is written.
      begin
         int n = 0;
         int d0;
         start_session(8'h30);
         send(2'd0, 4'h5, 4'h5, 4'h5, 4'h5, 12'h000, 1'b0);
         while (wq.size() < 1 && n < 50) begin
            @(negedge clk);
            #1 n++;
         end
         chk("rm_first_write", 32'(wq.size()), 32'd1);
         @(posedge clk);
         #1 bus.mem_ready = 1'b0;
         send(2'd0, 4'h6, 4'h6, 4'h6, 4'h6, 12'h000, 1'b0);
         send(2'd0, 4'h7, 4'h7, 4'h7, 4'h7, 12'h000, 1'b1);
         d0 = done_cnt;
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         chk("rm_in_ready", 32'(bus.in_ready), 32'd0);
         chk("rm_mem_we", 32'(bus.mem_we), 32'd0);
         chk("rm_mem_addr", 32'(bus.mem_addr), 32'd0);
         chk("rm_mem_wdata", 32'(bus.mem_wdata), 32'd0);
         chk("rm_busy", 32'(bus.busy), 32'd0);
         chk("rm_word_count", 32'(bus.word_count), 32'd0);
         bus.mem_ready = 1'b1;
         repeat (5) @(negedge clk);
         chk("rm_no_done", 32'(done_cnt - d0), 32'd0);
         chk("rm_no_more_writes", 32'(wq.size()), 32'd1);
         start_session(8'h50);
         send(2'd2, 4'h7, 4'h0, 4'h0, 4'h0, 12'h777, 1'b1);
         wait_done("rm_new");
         chk("rm_new_nwrites", 32'(wq.size()), 32'd1);
         chk_wr("rm_new_w0", 0, 8'h50, 16'h7777);
         chk("rm_new_word_count", 32'(bus.word_count), 32'd1);
      end

      // Address end: base two below the top of the 8-bit space.
      start_session(8'hFE);
      for (int i = 1; i <= 4; i++)
         send(2'd2, 4'(i), 4'h0, 4'h0, 4'h0, 12'(i), (i == 4) ? 1'b1 : 1'b0);
      wait_done("end");
      chk_wr("end_w0", 0, 8'hFE, 16'h1001);
      chk_wr("end_w1", 1, 8'hFF, 16'h2002);
`ifdef ENC_WRAP_EN
      chk("end_nwrites", 32'(wq.size()), 32'd4);
      chk_wr("end_w2", 2, 8'h00, 16'h3003);
      chk_wr("end_w3", 3, 8'h01, 16'h4004);
      chk("end_err", 32'(bus.err), 32'd0);
      chk("end_word_count", 32'(bus.word_count), 32'd4);
      chk("end_addr", 32'(bus.mem_addr), 32'h02);
`else
      chk("end_nwrites", 32'(wq.size()), 32'd2);
      chk("end_err", 32'(bus.err), 32'd1);
      chk("end_word_count", 32'(bus.word_count), 32'd2);
      chk("end_addr", 32'(bus.mem_addr), 32'hFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
